// File: rtl/melody_pkg.sv
// Shared definitions for the melody sequencer: note codes, pitch lookup,
// FSM states and the default song ROM.
package melody_pkg;

  localparam logic [3:0] REST = 4'd0;
  localparam logic [3:0] A4   = 4'd1;
  localparam logic [3:0] B4   = 4'd2;
  localparam logic [3:0] C5   = 4'd3;
  localparam logic [3:0] D5   = 4'd4;
  localparam logic [3:0] E5   = 4'd5;
  localparam logic [3:0] F5   = 4'd6;
  localparam logic [3:0] G5   = 4'd7;
  localparam logic [3:0] END  = 4'd15;

  typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, DONE} state_e;

  typedef struct packed {
    logic [3:0] code;
    logic [7:0] dur;
  } rom_entry_t;

  // Half-period in 25 MHz cycles; anything that is not a pitch is silence.
  function automatic logic [15:0] half_period_of(input logic [3:0] code);
    case (code)
      A4:      return 16'd28409;
      B4:      return 16'd25303;
      C5:      return 16'd23900;
      D5:      return 16'd21294;
      E5:      return 16'd18968;
      F5:      return 16'd17908;
      G5:      return 16'd15964;
      default: return 16'd0;
    endcase
  endfunction

  localparam rom_entry_t SONG_ROM [16] = '{
    {E5, 8'd20}, {E5, 8'd20}, {F5, 8'd20}, {G5, 8'd20},
    {REST, 8'd10}, {A4, 8'd0}, {G5, 8'd20}, {F5, 8'd20},
    {E5, 8'd20}, {D5, 8'd20}, {C5, 8'd20}, {C5, 8'd20},
    {D5, 8'd20}, {E5, 8'd20}, {E5, 8'd40}, {END, 8'd0}
  };

endpackage

// File: rtl/melody_sequencer_tick_divider.sv
// Duration prescaler: counts 0..TICK_DIV-1 and pulses tick on the wrap cycle.
module tick_divider #(
  parameter int TICK_DIV = 250000
) (
  input  logic clk_25mhz,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + PW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/melody_sequencer.sv
// Steps through the song ROM and drives the tone generator's half-period,
// with per-note durations, an articulation gap and play/stop/loop control.
module melody_sequencer
  import melody_pkg::*;
#(
  parameter int         TICK_DIV  = 250000,
  parameter int         GAP_TICKS = 2,
  parameter int         SONG_LEN  = 16,
  parameter rom_entry_t ROM [SONG_LEN] = SONG_ROM,
  localparam int        IW = (SONG_LEN > 1) ? $clog2(SONG_LEN) : 1
) (
  input  logic          clk_25mhz,
  input  logic          resetn,
  input  logic          play,
  input  logic          stop,
  input  logic          loop,
  output logic [15:0]   half_period,
  output logic [IW-1:0] note_index,
  output logic          playing,
  output logic          done
);

  localparam logic [7:0]    GAP_CNT  = 8'(GAP_TICKS);
  localparam logic [IW-1:0] LAST_IDX = IW'(SONG_LEN - 1);

  state_e        state_q, state_d, adv_state;
  logic          play_q;
  logic [IW-1:0] idx_q, idx_d, adv_idx;
  logic [15:0]   hp_q, hp_d;
  logic [7:0]    remain_q, remain_d;
  logic          clear, tick, start;
  rom_entry_t    entry;

  assign start = play & ~play_q;
  assign entry = ROM[idx_q];

  tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_25mhz (clk_25mhz),
    .resetn    (resetn),
    .clear     (clear),
    .tick      (tick)
  );

  // Where to go once a note (and its gap) is finished; the last slot acts as END.
  always_comb begin
    adv_state = LOAD;
    adv_idx   = idx_q + IW'(1);
    if (idx_q == LAST_IDX) begin
      adv_idx   = loop ? '0 : idx_q;
      adv_state = loop ? LOAD : DONE;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    hp_d     = hp_q;
    remain_d = remain_q;
    clear    = 1'b0;
    case (state_q)
      IDLE: begin
        hp_d = '0;
        if (start) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (entry.code == END) begin
          if (loop) idx_d = '0;
          else      state_d = DONE;
        end else begin
          state_d  = NOTE;
          hp_d     = half_period_of(entry.code);
          remain_d = (entry.dur == 8'd0) ? 8'd1 : entry.dur;
          clear    = 1'b1;
        end
      end
      NOTE: begin
        if (tick) begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            hp_d = '0;
            if (GAP_TICKS == 0) begin
              state_d = adv_state;
              idx_d   = adv_idx;
            end else begin
              state_d  = GAP;
              remain_d = GAP_CNT;
              clear    = 1'b1;
            end
          end
        end
      end
      GAP: begin
        if (tick) begin
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d = adv_state;
            idx_d   = adv_idx;
          end
        end
      end
      DONE: begin
        hp_d    = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Stop wins over everything, including a simultaneous start.
    if (stop) begin
      state_d = IDLE;
      hp_d    = '0;
      idx_d   = '0;
    end
  end

  always_ff @(posedge clk_25mhz or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      play_q   <= 1'b0;
      idx_q    <= '0;
      hp_q     <= '0;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      play_q   <= play;
      idx_q    <= idx_d;
      hp_q     <= hp_d;
      remain_q <= remain_d;
    end
  end

  assign half_period = hp_q;
  assign note_index  = idx_q;
  assign playing     = (state_q == LOAD) || (state_q == NOTE) || (state_q == GAP);
  assign done        = (state_q == DONE);

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
- Upstream stage of the square-wave tone generator.
- Steps through a fixed song ROM and drives the tone generator's half-period input one note at a time. A half-period of 0 means silence.
- Applies a timed duration and an articulation gap between notes. Supports play, stop and loop controls taken from the board buttons.

Parameters:
- TICK_DIV, 250000, clk_25mhz cycles per duration tick (10 ms at 25 MHz).
- GAP_TICKS, 2, silent ticks inserted after every note, including rests.
- SONG_LEN, 16, number of song ROM entries. Index width is clog2(SONG_LEN).

Ports:
- clk_25mhz, input, 1, system clock; the only clock.
- resetn, input, 1, asynchronous active-low reset.
- play, input, 1, level input; start is triggered on its rising edge.
- stop, input, 1, level input; returns the block to IDLE.
- loop, input, 1, level input; sampled when the end of the song is reached.
- half_period, output, 16, tone half-period in clk_25mhz cycles; 0 = silence.
- note_index, output, clog2(SONG_LEN), ROM index currently sounding.
- playing, output, 1, high in LOAD, NOTE and GAP.
- done, output, 1, one-cycle pulse when the song ends without looping.

Behaviour:
- Reset: asynchronous, while resetn=0.
  - state=IDLE; half_period=0, note_index=0, playing=0, done=0.
  - play_q=0; prescaler=0; remain=0.
- Edge detect: play_q registers play each cycle. start = play & ~play_q.
- ROM entry format: {code[3:0], dur[7:0]}.
  - code 0 = rest; codes 1..7 = A4,B4,C5,D5,E5,F5,G5; code 15 = END; codes 8..14 are treated as rest.
  - dur=0 is treated as 1.
- Tick generation: prescaler counts 0..TICK_DIV-1 and tick pulses on the wrap cycle. Prescaler is cleared on every entry to NOTE or GAP, so NOTE lasts exactly dur*TICK_DIV cycles and GAP lasts exactly GAP_TICKS*TICK_DIV cycles.
- State IDLE:
  - half_period=0.
  - start -> LOAD with note_index=0.
- State LOAD (1 cycle):
  - Read ROM[note_index].
  - If code=END: loop=1 -> note_index=0, remain in LOAD; loop=0 -> DONE.
  - Otherwise -> NOTE, with half_period=HALF_PERIOD[code] and remain=dur.
- State NOTE:
  - On tick, remain decrements.
  - On the tick where remain=1 -> GAP, with half_period=0 and remain=GAP_TICKS.
  - If GAP_TICKS=0, go directly to advance instead.
- State GAP:
  - On the tick where remain=1 -> advance.
- Advance:
  - note_index+1 -> LOAD.
  - If note_index=SONG_LEN-1, treat as END: loop gives index 0 and LOAD; otherwise DONE.
- State DONE (1 cycle): done=1, half_period=0 -> IDLE; note_index holds its last value.
- Latency: start sampled at clock edge N → LOAD after edge N → half_period valid after edge N+1.
- stop handling:
  - stop=1 in any state takes effect at the next edge: IDLE, half_period=0, playing=0, note_index=0, no done pulse.
  - stop takes precedence over start in the same cycle.
- play edges while playing=1 are ignored (no restart).
- loop is sampled only at END / last-index points; changing it mid-song has no other effect.
- Half-period values use integer division 25000000/f/2:
  - A4=28409, B4=25303, C5=23900, D5=21294, E5=18968, F5=17908, G5=15964.
- Counter widths: remain 8 bits; prescaler clog2(TICK_DIV) bits. No overflow is possible.

Decomposition:
- Package melody_pkg holds:
  - note code constants (REST, A4..G5, END);
  - HALF_PERIOD lookup function;
  - state enum (IDLE, LOAD, NOTE, GAP, DONE);
  - SONG_ROM constant array.
- Default SONG_ROM:
  - entry0={E5,20}, entry1={E5,20}, entry2={F5,20}, entry3={G5,20}, entry4={REST,10}, entry5={A4,0};
  - entries 6..14 are melody notes; entry15=END.
  - Benches may override SONG_ROM via the package.
- Sub-module tick_divider (parameter TICK_DIV; ports clk_25mhz, resetn, clear, tick) isolates the prescaler.

Test Plan:
- All tests use TICK_DIV=4 and GAP_TICKS=2.
- Reset mid-NOTE: assert resetn=0 while half_period=18968 -> all outputs are 0 within the same cycle (asynchronous); after release, state is IDLE and no sound until the next play edge.
- Basic play: play rises at edge N -> half_period=18968 and note_index=0 after edge N+1, held 80 cycles; then 0 for 8 cycles; then LOAD; then 18968 again with note_index=1.
- Rest and dur=0: entry4 gives half_period=0 for 40 cycles plus an 8-cycle gap; entry5 gives 28409 for exactly 4 cycles.
- End without loop: 3-entry ROM {C5,1},{D5,1},{END} with loop=0 -> done=1 for exactly 1 cycle after the last gap, then IDLE and playing=0; holding play high does not restart.
- Loop: same ROM with loop=1 -> after END, note_index=0 and half_period=23900 again with no done pulse; drop loop mid-song -> done after the next pass.
- Stop precedence: stop=1 during NOTE -> half_period=0 and IDLE after 1 edge; stop and a play edge in the same cycle -> stays IDLE.
